// File: rtl/step_run_controller_if.sv
// Bundle of the step/run controller's board-side and datapath-side signals.
// The master drives the key, switch and breakpoint inputs; the slave is the controller.
interface step_run_controller_if #(
   parameter int CNT_W = 16
) ();
   logic             key_n;
   logic             run_sw;
   logic [31:0]      pc_in;
   logic [31:0]      bp_addr;
   logic             bp_en;
   logic             cpu_en;
   logic             halted;
   logic             key_db;
   logic [CNT_W-1:0] step_cnt;

   modport master (
      output key_n, run_sw, pc_in, bp_addr, bp_en,
      input  cpu_en, halted, key_db, step_cnt
   );

   modport slave (
      input  key_n, run_sw, pc_in, bp_addr, bp_en,
      output cpu_en, halted, key_db, step_cnt
   );
endinterface

// File: rtl/step_run_controller.sv
// Clock-enable generator for the multi-cycle MIPS datapath: a debounced key gives
// single steps, the run switch gives a divided pulse rate, a PC breakpoint halts run mode.
module step_run_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RUN_DIV         = 25000000,
   parameter int CNT_W           = 16
) (
   input  logic                 clk,
   input  logic                 in_reset,
   step_run_controller_if.slave io
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_STEP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   state_e           state_q,       state_d;
   logic             key_meta_q,    key_meta_d;
   logic             key_s_q,       key_s_d;
   logic             run_meta_q,    run_meta_d;
   logic             run_s_q,       run_s_d;
   logic             run_prev_q,    run_prev_d;
   logic [DB_W-1:0]  db_cnt_q,      db_cnt_d;
   logic             key_db_q,      key_db_d;
   logic             key_db_prev_q, key_db_prev_d;
   logic             press_q,       press_d;
   logic [DIV_W-1:0] div_q,         div_d;
   logic             cpu_en_q,      cpu_en_d;
   logic             halted_q,      halted_d;
   logic [CNT_W-1:0] step_cnt_q,    step_cnt_d;

   logic db_mismatch;
   logic run_rise;
   logic bp_hit;

   // key_s is active-low, key_db active-high: they disagree when they are equal
   assign db_mismatch = (key_s_q == key_db_q);
   assign run_rise    = run_s_q & ~run_prev_q;
   assign bp_hit      = io.bp_en & (io.pc_in == io.bp_addr);

   assign io.cpu_en   = cpu_en_q;
   assign io.halted   = halted_q;
   assign io.key_db   = key_db_q;
   assign io.step_cnt = step_cnt_q;

   // synchronisers, debounce counter and the one-cycle press event
   always_comb begin
      key_meta_d    = io.key_n;
      key_s_d       = key_meta_q;
      run_meta_d    = io.run_sw;
      run_s_d       = run_meta_q;
      run_prev_d    = run_s_q;
      key_db_prev_d = key_db_q;
      press_d       = key_db_q & ~key_db_prev_q;
      key_db_d      = key_db_q;
      db_cnt_d      = {DB_W{1'b0}};
      if (db_mismatch) begin
         if (db_cnt_q == DB_LAST) begin
            key_db_d = ~key_db_q;
            db_cnt_d = {DB_W{1'b0}};
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end else begin
         db_cnt_d = {DB_W{1'b0}};
      end
   end

   // mode FSM, run divider and pulse generation
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cpu_en_d = 1'b0;
      case (state_q)
         ST_STEP: begin
            div_d = {DIV_W{1'b0}};
            if (run_rise) begin
               state_d = ST_RUN;
            end else if (press_q) begin
               cpu_en_d = 1'b1;
            end else begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!run_s_q) begin
               state_d = ST_STEP;
               div_d   = {DIV_W{1'b0}};
            end else if (div_q == DIV_LAST) begin
               div_d = {DIV_W{1'b0}};
               if (bp_hit) begin
                  state_d = ST_HALT;
               end else begin
                  cpu_en_d = 1'b1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         ST_HALT: begin
            div_d = {DIV_W{1'b0}};
            if (press_q) begin
               cpu_en_d = 1'b1;
               state_d  = run_s_q ? ST_RUN : ST_STEP;
            end else if (!run_s_q) begin
               state_d = ST_STEP;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_STEP;
            div_d   = {DIV_W{1'b0}};
         end
      endcase

      // a pulse is never allowed to stretch into a second cycle
      cpu_en_d = cpu_en_d & ~cpu_en_q;
      halted_d = (state_d == ST_HALT);
      if (cpu_en_d && (step_cnt_q != CNT_MAX)) begin
         step_cnt_d = step_cnt_q + CNT_W'(1);
      end else begin
         step_cnt_d = step_cnt_q;
      end
   end

   // state register; synchronisers reset to the idle levels of their inputs
   always_ff @(posedge clk or negedge in_reset) begin
      if (!in_reset) begin
         state_q       <= ST_STEP;
         key_meta_q    <= 1'b1;
         key_s_q       <= 1'b1;
         run_meta_q    <= 1'b0;
         run_s_q       <= 1'b0;
         run_prev_q    <= 1'b0;
         db_cnt_q      <= {DB_W{1'b0}};
         key_db_q      <= 1'b0;
         key_db_prev_q <= 1'b0;
         press_q       <= 1'b0;
         div_q         <= {DIV_W{1'b0}};
         cpu_en_q      <= 1'b0;
         halted_q      <= 1'b0;
         step_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         key_meta_q    <= key_meta_d;
         key_s_q       <= key_s_d;
         run_meta_q    <= run_meta_d;
         run_s_q       <= run_s_d;
         run_prev_q    <= run_prev_d;
         db_cnt_q      <= db_cnt_d;
         key_db_q      <= key_db_d;
         key_db_prev_q <= key_db_prev_d;
         press_q       <= press_d;
         div_q         <= div_d;
         cpu_en_q      <= cpu_en_d;
         halted_q      <= halted_d;
         step_cnt_q    <= step_cnt_d;
      end
   end

endmodule

// File: tb/tb_step_run_controller.sv
// Bench for step_run_controller: directed scenarios plus a randomized phase, each
// cycle compared against a behavioural model of the step/run/halt rules.
module tb_step_run_controller;

   localparam int DB      = 4;
   localparam int RD      = 3;
   localparam int CW      = 4;
   localparam int CNT_SAT = (1 << CW) - 1;
   localparam int M_STEP  = 0;
   localparam int M_RUN   = 1;
   localparam int M_HALT  = 2;

   logic clk;
   logic in_reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pulses = 0;

   step_run_controller_if #(.CNT_W(CW)) bus ();

   step_run_controller #(
      .DEBOUNCE_CYCLES(DB),
      .RUN_DIV        (RD),
      .CNT_W          (CW)
   ) dut (
      .clk      (clk),
      .in_reset (in_reset),
      .io       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: history of sampled inputs, a run of disagreeing samples for the
   // debounce, an elapsed-tick count in run mode, and the resulting outputs.
   typedef struct {
      bit [1:0] key_hist;
      bit [2:0] run_hist;
      int       mode;
      int       ticks;
      int       stable;
      bit       db;
      bit       db_rose;
      bit       press;
      bit       cpu_en;
      bit       halted;
      int       cnt;
   } model_t;

   model_t mdl;

   function automatic model_t model_reset();
      model_t r;
      r.key_hist = 2'b11;
      r.run_hist = 3'b000;
      r.mode     = M_STEP;
      r.ticks    = 0;
      r.stable   = 0;
      r.db       = 1'b0;
      r.db_rose  = 1'b0;
      r.press    = 1'b0;
      r.cpu_en   = 1'b0;
      r.halted   = 1'b0;
      r.cnt      = 0;
      return r;
   endfunction

   function automatic model_t model_next(model_t m, bit key_n, bit run_sw,
                                         logic [31:0] pc, logic [31:0] bp, bit bp_en);
      model_t n;
      bit     pressed_lvl;
      bit     run_s;
      bit     run_rise;
      bit     pulse;
      n           = m;
      pressed_lvl = !m.key_hist[1];
      run_s       = m.run_hist[1];
      run_rise    = m.run_hist[1] && !m.run_hist[2];
      pulse       = 1'b0;
      n.key_hist  = {m.key_hist[0], key_n};
      n.run_hist  = {m.run_hist[1:0], run_sw};

      n.db_rose = 1'b0;
      if (pressed_lvl != m.db) begin
         n.stable = m.stable + 1;
         if (n.stable == DB) begin
            n.db      = !m.db;
            n.stable  = 0;
            n.db_rose = n.db;
         end
      end else begin
         n.stable = 0;
      end
      n.press = m.db_rose;

      case (m.mode)
         M_STEP: begin
            if (run_rise) begin
               n.mode  = M_RUN;
               n.ticks = 0;
            end else if (m.press) begin
               pulse = 1'b1;
            end
         end
         M_RUN: begin
            if (!run_s) begin
               n.mode = M_STEP;
            end else begin
               n.ticks = m.ticks + 1;
               if ((m.ticks % RD) == RD - 1) begin
                  if (bp_en && pc == bp) n.mode = M_HALT;
                  else pulse = 1'b1;
               end
            end
         end
         M_HALT: begin
            if (m.press) begin
               pulse   = 1'b1;
               n.mode  = run_s ? M_RUN : M_STEP;
               n.ticks = 0;
            end else if (!run_s) begin
               n.mode = M_STEP;
            end
         end
         default: n.mode = M_STEP;
      endcase

      n.cpu_en = pulse;
      n.halted = (n.mode == M_HALT);
      n.cnt    = (m.cnt + int'(pulse) > CNT_SAT) ? CNT_SAT : m.cnt + int'(pulse);
      return n;
   endfunction

   always @(posedge clk or negedge in_reset) begin
      if (!in_reset) mdl <= model_reset();
      else mdl <= model_next(mdl, bus.key_n, bus.run_sw, bus.pc_in, bus.bp_addr, bus.bp_en);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: compare at the falling edge, then let the "CPU" advance its PC
   task automatic tick();
      @(negedge clk);
      check_eq("cpu_en",   bus.cpu_en,   mdl.cpu_en);
      check_eq("halted",   bus.halted,   mdl.halted);
      check_eq("key_db",   bus.key_db,   mdl.db);
      check_eq("step_cnt", bus.step_cnt, mdl.cnt);
      if (bus.cpu_en === 1'b1) begin
         n_pulses++;
         bus.pc_in = bus.pc_in + 32'd4;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      int t;
      int last;
      int lat;
      int key_hold;

      // 1: reset holds everything at zero even with the key pressed and run requested
      in_reset    = 1'b0;
      bus.key_n   = 1'b0;
      bus.run_sw  = 1'b1;
      bus.pc_in   = 32'd0;
      bus.bp_addr = 32'd0;
      bus.bp_en   = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_cpu_en",   bus.cpu_en,   32'd0);
      check_eq("rst_halted",   bus.halted,   32'd0);
      check_eq("rst_key_db",   bus.key_db,   32'd0);
      check_eq("rst_step_cnt", bus.step_cnt, 32'd0);
      bus.run_sw = 1'b0;
      bus.key_n  = 1'b1;
      in_reset   = 1'b1;
      p0 = n_pulses;
      repeat (12) tick();
      check_eq("rst_idle_pulses", n_pulses - p0, 32'd0);

      // 2: short bounces are rejected, a held press gives one pulse
      p0 = n_pulses;
      for (int b = 0; b < 3; b++) begin
         bus.key_n = 1'b0;
         repeat (2) tick();
         bus.key_n = 1'b1;
         repeat ($urandom_range(3, 6)) tick();
      end
      repeat (6) tick();
      check_eq("bounce_key_db", bus.key_db, 32'd0);
      check_eq("bounce_pulses", n_pulses - p0, 32'd0);
      bus.key_n = 1'b0;
      p0  = n_pulses;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (bus.cpu_en === 1'b1 && lat < 0) lat = i - 1;
      end
      check_eq("press_latency", lat, 32'd7);
      bus.key_n = 1'b1;
      repeat (12) tick();
      check_eq("press_pulses", n_pulses - p0, 32'd1);
      check_eq("press_step_cnt", bus.step_cnt, 32'd1);
      check_eq("release_key_db", bus.key_db, 32'd0);

      // 3: run mode pulses every RD cycles, step counter saturates
      bus.run_sw = 1'b1;
      p0 = n_pulses; t = 0; last = -1;
      while (n_pulses - p0 < 20 && t < 200) begin
         tick(); t++;
         if (bus.cpu_en === 1'b1) begin
            if (last >= 0) check_eq("run_period", t - last, RD);
            last = t;
         end
      end
      check_eq("run_pulses", n_pulses - p0, 32'd20);
      check_eq("run_cnt_sat", bus.step_cnt, CNT_SAT);

      // 4: breakpoint at 0xC halts after the pulses for PC 0, 4 and 8
      bus.pc_in   = 32'd0;
      bus.bp_addr = 32'h0000_000C;
      bus.bp_en   = 1'b1;
      p0 = n_pulses; t = 0;
      while (bus.halted !== 1'b1 && t < 30) begin
         tick(); t++;
      end
      check_eq("bp_pulses", n_pulses - p0, 32'd3);
      check_eq("bp_halted", bus.halted, 32'd1);
      p0 = n_pulses;
      repeat (20) tick();
      check_eq("halt_quiet", n_pulses - p0, 32'd0);
      check_eq("halt_hold", bus.halted, 32'd1);

      // 5: a press steps past the breakpoint and run mode resumes
      bus.key_n = 1'b0;
      p0 = n_pulses; t = 0;
      while (n_pulses == p0 && t < 20) begin
         tick(); t++;
      end
      check_eq("resume_one_pulse", n_pulses - p0, 32'd1);
      check_eq("resume_halted", bus.halted, 32'd0);
      p0 = n_pulses; t = 0;
      while (n_pulses == p0 && t < 10) begin
         tick(); t++;
      end
      check_eq("resume_period", t, RD);
      bus.key_n = 1'b1;
      repeat (12) tick();

      // 6a: run_s falls exactly on a terminal cycle, so that pulse is suppressed
      p0 = n_pulses; t = 0;
      while (n_pulses == p0 && t < 10) begin
         tick(); t++;
      end
      bus.run_sw = 1'b0;
      p0 = n_pulses;
      repeat (8) tick();
      check_eq("drop_no_pulse", n_pulses - p0, 32'd0);
      check_eq("drop_not_halted", bus.halted, 32'd0);

      // 6b: run_rise and press land in the same cycle; only the mode change happens
      bus.key_n = 1'b0;
      repeat (5) tick();
      bus.run_sw = 1'b1;
      p0  = n_pulses;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (bus.cpu_en === 1'b1 && lat < 0) lat = i;
      end
      check_eq("coinc_first_pulse", lat, 32'd6);
      check_eq("coinc_pulses", n_pulses - p0, 32'd1);
      bus.key_n = 1'b1;

      // randomized phase with an asynchronous reset partway through
      key_hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if (key_hold == 0) begin
            bus.key_n = 1'($urandom_range(0, 1));
            key_hold  = $urandom_range(1, 10);
         end
         key_hold--;
         if ($urandom_range(0, 39) == 0) bus.run_sw = ~bus.run_sw;
         if ($urandom_range(0, 19) == 0) begin
            bus.bp_en   = 1'($urandom_range(0, 1));
            bus.bp_addr = bus.pc_in + 32'($urandom_range(0, 3) * 4);
         end
         if (c == 700) begin
            #2 in_reset = 1'b0;
            #1;
            check_eq("async_rst_cpu_en",   bus.cpu_en,   32'd0);
            check_eq("async_rst_halted",   bus.halted,   32'd0);
            check_eq("async_rst_key_db",   bus.key_db,   32'd0);
            check_eq("async_rst_step_cnt", bus.step_cnt, 32'd0);
            repeat (3) tick();
            in_reset = 1'b1;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/step_run_controller.md
Name: step_run_controller

Overview:
- Clock-enable generator directly upstream of the multi-cycle MIPS datapath on the DE2 board.
- Replaces the raw pushbutton clock. Inputs are debounced and synchronised to the 50 MHz board clock.
- Emits single-cycle cpu_en pulses in one of two ways: one pulse per key press (step mode), or at a divided rate (run mode). Run mode halts when the PC hits a breakpoint.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles (10 ms at 50 MHz) required before the debounced key level changes.
- RUN_DIV, 25000000: clocks between cpu_en pulses in run mode (2 Hz).
- CNT_W, 16: width of the step counter.

Ports:
- clk  in  1  50 MHz board clock; all state on rising edge.
- in_reset  in  1  asynchronous, active-low reset (0 = reset).
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- run_sw  in  1  raw slide switch; 1 = run mode requested; asynchronous.
- pc_in  in  32  current processor PC.
- bp_addr  in  32  breakpoint address.
- bp_en  in  1  breakpoint enable (1 = armed).
- cpu_en  out  1  one-cycle clock-enable pulse to the datapath.
- halted  out  1  1 while in HALT state.
- key_db  out  1  debounced key level; 1 = pressed.
- step_cnt  out  CNT_W  count of cpu_en pulses issued; saturates at all-ones.

Behaviour:
Reset
- in_reset=0 forces, asynchronously, within the same cycle:
  - state=STEP
  - cpu_en=0, halted=0, key_db=0, step_cnt=0
  - debounce counter=0, divider=0
  - key_n synchroniser flops=1, run_sw synchroniser flops=0
- Reset mid-pulse or mid-count aborts with no further pulse.

Input synchronisation and debounce
- key_n and run_sw each pass through 2-flop synchronisers: key_s, run_s.
- Debounce counter:
  - Counts while ~key_s differs from key_db; clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 with a mismatch still present, key_db toggles and the counter clears.
- press = key_db rising edge, a registered 1-cycle event.
- Input to press latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- run_rise = 0→1 transition of run_s.

States
- STEP:
  - press → cpu_en=1 next cycle, stay STEP.
  - run_rise → RUN with divider=0; takes priority over a simultaneous press (the press is dropped).
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - At terminal count, if bp_en=1 and pc_in==bp_addr: go to HALT, no pulse. Otherwise cpu_en=1.
  - run_s=0 → STEP; divider clears; a coincident terminal pulse is suppressed.
  - press is ignored.
- HALT:
  - halted=1; divider frozen at 0.
  - press with run_s=1 → one cpu_en pulse, return to RUN with divider=0. This steps past the breakpoint. The next compare occurs only at the next terminal count.
  - press with run_s=0 → one cpu_en pulse, go to STEP.
  - run_s=0 with no press → STEP, no pulse.

Pulse rules
- cpu_en is registered and never high for two consecutive cycles.
- Each cpu_en pulse increments step_cnt in the same edge, saturating at 2^CNT_W-1.

Test Plan:
Use DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4 for all scenarios.
1. Reset: hold in_reset=0 with key_n=0 and run_sw=1 → all outputs 0. Release → state STEP, no cpu_en until a debounced press.
2. Bounce rejection: key_n pulses low for 2 cycles, 3 times → key_db stays 0, no cpu_en. Then hold low for 10 cycles → exactly one cpu_en, 7 cycles after the held edge; step_cnt=1. Release → no pulse.
3. Run mode: run_sw=1, bp_en=0 → cpu_en every 3 cycles. After 20 pulses, step_cnt=15 (saturated).
4. Breakpoint: RUN with bp_addr=0x0000000C, bp_en=1, pc_in stepping 0,4,8,C on each pulse → pulses for PC 0, 4, 8. At PC=C: halted=1, no further cpu_en over 20 cycles.
5. Resume from HALT: press → exactly one cpu_en; halted=0 next cycle; pc_in=0x10 → periodic pulses resume 3 cycles later.
6. Mode change at terminal: drop run_sw so run_s falls on the divider's terminal cycle → no pulse, state STEP. Raise run_sw together with a coincident press → RUN only, the press produces no extra pulse.
